// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: CP0 register addresses, exception codes, field indices and write masks
package cp0_exc_ctrl_pkg;
  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;
  localparam logic [4:0] A_CONFIG   = 5'd16;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int IP_LO  = 8;
  localparam int IP_HI  = 15;
  localparam int EC_LO  = 2;
  localparam int EC_HI  = 6;
  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
  function automatic logic [31:0] wmask(input logic [4:0] a);
    return (a == A_COUNT || a == A_COMPARE || a == A_STATUS || a == A_EPC) ? 32'hFFFF_FFFF :
           a == A_CAUSE ? CAUSE_WMASK : 32'h0;
  endfunction
endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// cp0_int_sync: SYNC_STAGES-deep flop synchroniser for the external interrupt lines
module cp0_int_sync #(
  parameter int N = 6,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] r [S];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S; i++) r[i] <= '0;
    end else begin
      r[0] <= d;
      for (int i = 1; i < S; i++) r[i] <= r[i-1];
    end
  end
  assign q = r[S-1];
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register file with timer, interrupt request and exception/ERET redirect
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int          NUM_HW_INT  = 6,
  parameter int          COUNT_DIV   = 1,
  parameter logic [31:0] EXC_BASE    = 32'hBFC0_0200,
  parameter logic [31:0] PRID_VAL    = 32'h004C_0102,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           data_o,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_in_ds_i,
  input  logic [31:0]           badvaddr_i,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);
  logic [31:0] count, compare, status, cause_r, epc, badvaddr;
  logic [31:0] status_n, cause_n, epc_n, cause_v, cur, m;
  logic [3:0] pre;
  logic [NUM_HW_INT-1:0] sync_q;
  logic [5:0] hw;
  logic timer, inc, wr_count, wr_compare, exl, eret;
  cp0_int_sync #(.N(NUM_HW_INT), .S(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(int_i),
    .q(sync_q)
  );
  assign hw         = 6'(sync_q);
  assign exl        = status[ST_EXL];
  assign eret       = eret_i & ~exc_valid_i;
  assign inc        = pre == 4'(COUNT_DIV - 1);
  assign wr_count   = we_i && waddr_i == A_COUNT;
  assign wr_compare = we_i && waddr_i == A_COMPARE;
  // the timer shares IP[7] with the top hardware line
  assign cause_v = cause_r | {16'h0, hw[5] | timer, hw[4:0], 10'h0};
  always_comb begin
    status_n = (we_i && waddr_i == A_STATUS) ? data_i : status;
    cause_n  = (we_i && waddr_i == A_CAUSE) ? (cause_r & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK) : cause_r;
    epc_n    = (we_i && waddr_i == A_EPC) ? data_i : epc;
    if (exc_valid_i) begin
      status_n[ST_EXL]      = 1'b1;
      cause_n[EC_HI:EC_LO]  = exc_code_i;
      if (!exl) begin
        cause_n[CA_BD] = exc_in_ds_i;
        epc_n          = exc_in_ds_i ? exc_pc_i - 32'd4 : exc_pc_i;
      end
    end else if (eret) begin
      status_n[ST_EXL] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      count    <= '0;
      compare  <= '0;
      timer    <= 1'b0;
      status   <= STATUS_RST;
      cause_r  <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      pre      <= (wr_count || inc) ? 4'd0 : pre + 4'd1;
      count    <= wr_count ? data_i : inc ? count + 32'd1 : count;
      compare  <= wr_compare ? data_i : compare;
      timer    <= wr_compare ? 1'b0 :
                  (inc && !wr_count && count + 32'd1 == compare && compare != 32'd0) ? 1'b1 : timer;
      status   <= status_n;
      cause_r  <= cause_n;
      epc      <= epc_n;
      badvaddr <= (exc_valid_i && (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES)) ? badvaddr_i : badvaddr;
    end
  end
  always_comb begin
    cur = raddr_i == A_COUNT    ? count :
          raddr_i == A_COMPARE  ? compare :
          raddr_i == A_STATUS   ? status :
          raddr_i == A_CAUSE    ? cause_v :
          raddr_i == A_EPC      ? epc :
          raddr_i == A_PRID     ? PRID_VAL :
          raddr_i == A_CONFIG   ? CONFIG_VAL :
          raddr_i == A_BADVADDR ? badvaddr : 32'h0;
    m = wmask(raddr_i);
    data_o = rst ? 32'h0 : (we_i && waddr_i == raddr_i) ? (data_i & m) | (cur & ~m) : cur;
  end
  assign int_req_o   = ~rst & (|(cause_v[IP_HI:IP_LO] & status[IP_HI:IP_LO])) & status[ST_IE] & ~exl;
  assign flush_o     = ~rst & (exc_valid_i | eret_i);
  assign new_pc_o    = rst ? 32'h0 : exc_valid_i ? EXC_BASE + 32'h180 : eret ? epc : 32'h0;
  assign status_o    = status;
  assign cause_o     = cause_v;
  assign epc_o       = epc;
  assign timer_int_o = timer;
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised next-generation CP0 block holding Count, Compare, Status, Cause, EPC, BadVAddr, Config and PRId.
- Adds a Count prescaler, synchronised hardware interrupt inputs, interrupt-request generation, BadVAddr capture, and exception/ERET redirect (flush + new PC).
- Sits beside the MEM stage. The pipeline presents one already-prioritised exception per cycle with its own PC and delay-slot flag.

Parameters:
- NUM_HW_INT, 6, number of external interrupt lines mapped to Cause.IP[2+NUM_HW_INT-1:2]; range 1..6.
- COUNT_DIV, 1, Count increments once every COUNT_DIV cycles; range 1..16.
- EXC_BASE, 32'hBFC0_0200, exception vector base; general vector = EXC_BASE + 32'h180.
- PRID_VAL, 32'h004C_0102, PRId reset/constant value.
- SYNC_STAGES, 2, synchroniser depth on int_i; range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- raddr_i  in  5  MFC0 register address
- data_o  out  32  MFC0 read data
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 register address
- data_i  in  32  MTC0 write data
- int_i  in  NUM_HW_INT  asynchronous external interrupt lines
- exc_valid_i  in  1  exception commit this cycle
- exc_code_i  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov, 13 Tr)
- eret_i  in  1  ERET commit this cycle
- exc_pc_i  in  32  PC of the excepting instruction
- exc_in_ds_i  in  1  instruction is in a delay slot
- badvaddr_i  in  32  faulting address for AdEL/AdES
- int_req_o  out  1  interrupt should be taken
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target
- status_o, cause_o, epc_o  out  32 each  register views for the pipeline
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Reset values: Count 0; Compare 0; Status 32'h1000_0000 (CU0=1); Cause 0; EPC 0; BadVAddr 0; Config 32'h0000_8000; PRId PRID_VAL; prescaler 0; synchroniser flops 0; timer_int_o 0.
- Combinational outputs derived from these state values (flush_o, new_pc_o, int_req_o) therefore also reset to 0.
- Prescaler: counts 0..COUNT_DIV-1. Count += 1 (mod 2^32) on wrap. With COUNT_DIV=1, Count increments every cycle.
- Timer: timer_int_o sets on the cycle Count is incremented to a value equal to Compare, with Compare != 0. It stays set until an MTC0 to Compare, which clears it at the same edge.
- MTC0 to Count writes Count and clears the prescaler. A write overrides that cycle's increment.
- Interrupt lines: int_i passes through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency into Cause.IP.
  - Cause.IP[7] = sync[5] | timer_int_o (timer shares the top line).
  - Cause.IP bits without a line read 0.
  - Cause.IP[1:0] are software-writable.
- Writable fields:
  - Status: all bits.
  - Cause: IP[1:0], IV(23), WP(22).
  - Compare, EPC: all bits.
  - BadVAddr, PRId, Config: read-only; writes are ignored.
- int_req_o (combinational) = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
- On exc_valid_i, at the next edge:
  - If EXL=0: EPC = exc_in_ds_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD = exc_in_ds_i. If EXL=1, EPC and BD are unchanged (nested exception).
  - Always: EXL=1 and Cause.ExcCode = exc_code_i.
  - For codes 4/5 only: BadVAddr = badvaddr_i.
- Exception redirect (combinational, same cycle): flush_o=1, new_pc_o = EXC_BASE+32'h180.
- ERET (eret_i & ~exc_valid_i): flush_o=1, new_pc_o = EPC (current value); EXL cleared at the edge.
- If exc_valid_i and eret_i are both high, the exception wins and ERET is ignored.
- If an exception and MTC0 occur in the same cycle, exception-written fields (EPC, BD, ExcCode, EXL, BadVAddr) take the exception value; other written fields take data_i.
- Read path (combinational): MTC0 forwarding. When we_i and waddr_i==raddr_i, data_o is the post-write-mask value of data_i merged with the unwritable bits. Unmapped addresses read 0. When rst=1, data_o = 0.
- Otherwise flush_o=0 and new_pc_o=0.
- Reset asserted mid-operation restores all reset values at the next edge, including a pending timer interrupt and the synchroniser contents.

Decomposition:
- Shared package/defines:
  - CP0 register addresses (Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16, BadVAddr 8).
  - ExcCode constants.
  - Status/Cause bit-field indices.
  - Writable-mask constants.
- One sub-module: cp0_int_sync, a parametrised SYNC_STAGES x NUM_HW_INT flop synchroniser.

Test Plan:
- Reset, then MFC0 PRId and Config -> 32'h004C_0102 and 32'h0000_8000; Status reads 32'h1000_0000.
- COUNT_DIV=2, Compare=5 -> timer_int_o rises 10 cycles after the Count write of 0; MTC0 Compare=20 clears it at that edge.
- Status.IE=1, IM[2]=1, pulse int_i[0] -> IP[2] set after SYNC_STAGES cycles; int_req_o=1 the same cycle; it drops after EXL is set.
- exc_valid_i with code 8, exc_pc_i=32'h100, in_ds=1 -> EPC=32'hFC, BD=1, EXL=1, flush_o=1, new_pc_o=32'hBFC0_0380. A second exception while EXL=1 leaves EPC=32'hFC.
- AdEL with badvaddr_i=32'hDEAD_BEE1 -> BadVAddr=32'hDEAD_BEE1, ExcCode=4. eret_i then gives new_pc_o=EPC and EXL=0 after the edge.
- MTC0 Cause=32'hFFFF_FFFF with same-cycle raddr=13 -> data_o shows only IP[1:0], IV and WP set, plus synchronised IP bits.
